// File: rtl/aer_spike_decoder.sv
// rtl/aer_spike_decoder.sv - AER event receiver: event FIFO plus fixed-length one-hot row strobe
// Optional feature macro: AER_EVENT_COUNT_EN (adds the 16-bit delivered-strobe counter event_count)
module aer_spike_decoder #(
  parameter int NUM_SYNAPSE_ROWS = 4,
  parameter int ADDR_W           = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1,
  parameter int FIFO_DEPTH       = 4,
  parameter int PULSE_CYCLES     = 2
) (
  input  logic                        main_clk,
  input  logic                        main_rst_n,
  input  logic                        aer_valid,
  output logic                        aer_ready,
  input  logic [ADDR_W-1:0]           aer_addr,
  input  logic                        enable,
  input  logic                        err_clr,
  output logic [NUM_SYNAPSE_ROWS-1:0] row_pulse,
  output logic                        busy,
  output logic                        err_addr
`ifdef AER_EVENT_COUNT_EN
  ,
  output logic [15:0]                 event_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [ADDR_W:0] ROW_LIMIT = (ADDR_W + 1)'(NUM_SYNAPSE_ROWS);
  localparam logic [NUM_SYNAPSE_ROWS-1:0] ROW_ONE = NUM_SYNAPSE_ROWS'(1);
  localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [PTR_W:0]              r_wr_ptr;
  logic [PTR_W:0]              r_rd_ptr;
  logic [ADDR_W-1:0]           r_mem [FIFO_DEPTH];
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [NUM_SYNAPSE_ROWS-1:0] r_row_pulse;
  logic [NUM_SYNAPSE_ROWS-1:0] w_row_nxt;
  logic                        r_err_addr;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_accept;
  logic                        w_in_range;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_start_ok;
  logic [ADDR_W-1:0]           w_head;

  // Full when pointers differ only in the wrap bit; empty when identical.
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                      (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign aer_ready  = !w_full;
  assign w_accept   = aer_valid && aer_ready;
  assign w_in_range = ({1'b0, aer_addr} < ROW_LIMIT);
  // Out-of-range words complete the handshake but never enter the buffer.
  assign w_push     = w_accept && w_in_range;
  assign w_head     = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign w_start_ok = enable && !w_empty;

  assign row_pulse  = r_row_pulse;
  assign busy       = !w_empty || (r_state != S_IDLE);
  assign err_addr   = r_err_addr;

  // Event storage; contents need no reset because the pointers define validity.
  always_ff @(posedge main_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= aer_addr;
    end
  end

  // FIFO pointer update; a pop and a push may happen in the same cycle.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Sticky address error; a new error in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_err_addr <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_err_addr <= 1'b1;
    end else if (err_clr) begin
      r_err_addr <= 1'b0;
    end
  end

  // Strobe FSM state register together with the registered strobe and its length counter.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_row_pulse <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row_pulse <= w_row_nxt;
    end
  end

  // Next-state logic; the GAP cycle is the single zero cycle between strobes and may launch the next one.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row_pulse;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE, S_GAP: begin
        w_row_nxt   = '0;
        w_state_nxt = S_IDLE;
        if (w_start_ok) begin
          w_pop       = 1'b1;
          w_row_nxt   = ROW_ONE << w_head;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = S_PULSE;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_row_nxt   = '0;
          w_state_nxt = S_GAP;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_row_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef AER_EVENT_COUNT_EN
  logic [15:0] r_event_count;

  // Saturating count of strobes launched; only reset clears it.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_event_count <= '0;
    end else if (w_pop && (r_event_count != 16'hFFFF)) begin
      r_event_count <= r_event_count + 16'd1;
    end
  end

  assign event_count = r_event_count;
`endif

endmodule
